// File: rtl/iq_capture_buf.sv
// Trigger-based I/Q snapshot buffer: records samples into a ring and, on a trigger,
// freezes PRETRIG samples before the trigger plus DEPTH-PRETRIG from the trigger onward.
module iq_capture_buf #(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 256,
  parameter int PRETRIG = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        din_I,
  input  logic [DATA_W-1:0]        din_Q,
  input  logic                     din_valid,
  input  logic                     sym_tick,
  input  logic                     ext_trig,
  input  logic                     trig_mode,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_I,
  output logic [DATA_W-1:0]        rd_Q,
  output logic                     rd_valid,
  output logic [2:0]               state_o,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_CNT  = CW'(PRETRIG);
  localparam logic [CW-1:0] POST_CNT = CW'(DEPTH - PRETRIG);
  localparam logic [AW-1:0] PRE_OFS  = AW'(PRETRIG);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     start_ptr_q, start_ptr_d;
  logic [CW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]     post_cnt_q, post_cnt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_i_q, rd_q_q;
  logic              rd_valid_q;

  logic [2*DATA_W-1:0] mem [DEPTH];

  logic          wr_en;
  logic          trig;
  logic [AW-1:0] rd_ptr;

  assign wr_en  = din_valid &&
                  (state_q == ST_PREFILL || state_q == ST_ARMED || state_q == ST_POST);
  assign trig   = (trig_mode ? ext_trig : sym_tick) & din_valid;
  assign rd_ptr = start_ptr_q + rd_addr;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    done_d      = done_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            wr_ptr_d   = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            done_d     = 1'b0;
            state_d    = (PRETRIG == 0) ? ST_ARMED : ST_PREFILL;
          end
        end
        ST_PREFILL: begin
          if (din_valid) begin
            pre_cnt_d = pre_cnt_q + CW'(1);
            if (pre_cnt_d == PRE_CNT) begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          // The trigger sample itself is written this cycle and counts as post sample 1.
          if (trig) begin
            start_ptr_d = wr_ptr_q - PRE_OFS;
            post_cnt_d  = CW'(1);
            if (POST_CNT == CW'(1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          if (din_valid) begin
            post_cnt_d = post_cnt_q + CW'(1);
            if (post_cnt_d == POST_CNT) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      done_q      <= done_d;
    end
  end

  // Sample store: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {din_I, din_Q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_i_q     <= '0;
      rd_q_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        {rd_i_q, rd_q_q} <= mem[rd_ptr];
      end
    end
  end

  assign rd_I     = rd_i_q;
  assign rd_Q     = rd_q_q;
  assign rd_valid = rd_valid_q;
  assign state_o  = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_iq_capture_buf.sv
// Directed bench for iq_capture_buf with DEPTH=16, PRETRIG=4 and a ramp stimulus
// (I=n, Q=-n, n counted from the first sample after arm).
module tb_iq_capture_buf;

  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din_I, din_Q;
  logic          din_valid, sym_tick, ext_trig, trig_mode, arm, abort, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_I, rd_Q;
  logic          rd_valid;
  logic [2:0]    state_o;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  iq_capture_buf #(.DATA_W(DW), .DEPTH(DEPTH), .PRETRIG(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .din_I(din_I), .din_Q(din_Q), .din_valid(din_valid),
    .sym_tick(sym_tick), .ext_trig(ext_trig), .trig_mode(trig_mode), .arm(arm),
    .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .rd_I(rd_I), .rd_Q(rd_Q),
    .rd_valid(rd_valid), .state_o(state_o), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic v, input logic et, input logic st);
    din_I     = DW'(n);
    din_Q     = DW'(-n);
    din_valid = v;
    ext_trig  = et;
    sym_tick  = st;
    step();
  endtask

  task automatic idle_inputs();
    din_valid = 1'b0;
    ext_trig  = 1'b0;
    sym_tick  = 1'b0;
  endtask

  task automatic pulse_arm();
    idle_inputs();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_read(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    step();
    rd_en = 1'b0;
    $display("read addr=%0d I=%0d Q=%0d valid=%0b", a, $signed(rd_I), $signed(rd_Q), rd_valid);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%0b exp=0", done); end
    n_cmp++; if (rd_I !== '0 || rd_Q !== '0) begin n_bad++; $display("FAIL rst_rd got=%0d/%0d exp=0/0", rd_I, rd_Q); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid got=%0b exp=0", rd_valid); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send(i, 1'b1, 1'b1, 1'b1);
    idle_inputs();
    n_cmp++; if (state_o !== 3'd0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_no_arm state=%0d done=%0b exp=0/0", state_o, done); end
  endtask

  task automatic test_basic();
    trig_mode = 1'b1;
    pulse_arm();
    n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL basic_prefill state=%0d exp=1", state_o); end
    for (int n = 0; n <= 3; n++) send(n, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL basic_armed state=%0d exp=2", state_o); end
    for (int n = 4; n <= 20; n++) send(n, 1'b1, n == 10, 1'b0);
    n_cmp++; if (state_o !== 3'd3 || done !== 1'b0) begin n_bad++; $display("FAIL basic_post state=%0d done=%0b exp=3/0", state_o, done); end
    send(21, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    n_cmp++; if (state_o !== 3'd4 || done !== 1'b1) begin n_bad++; $display("FAIL basic_done state=%0d done=%0b exp=4/1", state_o, done); end
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a);
      n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL basic_rd_valid addr=%0d got=%0b exp=1", a, rd_valid); end
      n_cmp++; if (rd_I !== DW'(6 + a) || rd_Q !== DW'(-(6 + a)))
        begin n_bad++; $display("FAIL basic_rd addr=%0d got=%0d/%0d exp=%0d/%0d", a, $signed(rd_I), $signed(rd_Q), 6 + a, -(6 + a)); end
    end
    step();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_rd_valid_drop got=%0b exp=0", rd_valid); end
    n_cmp++; if (rd_I !== DW'(21)) begin n_bad++; $display("FAIL basic_rd_hold got=%0d exp=21", $signed(rd_I)); end
  endtask

  task automatic test_reset_midrun();
    rd_en   = 1'b1;
    rd_addr = AW'(15);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (state_o !== 3'd0 || done !== 1'b0) begin n_bad++; $display("FAIL midrst_state state=%0d done=%0b exp=0/0", state_o, done); end
    n_cmp++; if (rd_I !== '0 || rd_Q !== '0 || rd_valid !== 1'b0)
      begin n_bad++; $display("FAIL midrst_rd got=%0d/%0d v=%0b exp=0/0 v=0", rd_I, rd_Q, rd_valid); end
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send(i, 1'b1, 1'b1, 1'b0);
    idle_inputs();
    n_cmp++; if (state_o !== 3'd0 || done !== 1'b0) begin n_bad++; $display("FAIL midrst_release state=%0d done=%0b exp=0/0", state_o, done); end
  endtask

  task automatic test_early_trigger();
    trig_mode = 1'b1;
    pulse_arm();
    for (int n = 0; n <= 18; n++) send(n, 1'b1, (n == 2) || (n == 7), 1'b0);
    idle_inputs();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL early_done got=%0b exp=1", done); end
    do_read(0);
    n_cmp++; if (rd_I !== DW'(3)) begin n_bad++; $display("FAIL early_addr0 got=%0d exp=3", $signed(rd_I)); end
    do_read(4);
    n_cmp++; if (rd_I !== DW'(7)) begin n_bad++; $display("FAIL early_addr4 got=%0d exp=7", $signed(rd_I)); end
    do_read(15);
    n_cmp++; if (rd_I !== DW'(18) || rd_Q !== DW'(-18)) begin n_bad++; $display("FAIL early_addr15 got=%0d/%0d exp=18/-18", $signed(rd_I), $signed(rd_Q)); end
  endtask

  task automatic test_wrap();
    int exp_i [5] = '{36, 40, 47, 48, 51};
    int addrs [5] = '{0, 4, 11, 12, 15};
    trig_mode = 1'b1;
    pulse_arm();
    for (int n = 0; n <= 51; n++) send(n, 1'b1, n == 40, 1'b0);
    idle_inputs();
    n_cmp++; if (done !== 1'b1 || state_o !== 3'd4) begin n_bad++; $display("FAIL wrap_done done=%0b state=%0d exp=1/4", done, state_o); end
    for (int i = 0; i < 5; i++) begin
      do_read(addrs[i]);
      n_cmp++; if (rd_I !== DW'(exp_i[i]) || rd_Q !== DW'(-exp_i[i]))
        begin n_bad++; $display("FAIL wrap_rd addr=%0d got=%0d/%0d exp=%0d/%0d", addrs[i], $signed(rd_I), $signed(rd_Q), exp_i[i], -exp_i[i]); end
    end
  endtask

  task automatic test_mode0_gaps();
    int exp_i [4] = '{3, 4, 7, 18};
    int addrs [4] = '{0, 1, 4, 15};
    trig_mode = 1'b0;
    pulse_arm();
    // Valid on even cycles; ext_trig (wrong source) at 10, sym_tick on an invalid cycle at 11,
    // first accepted sym_tick at cycle 14 (sample 7).
    for (int c = 0; c <= 36; c++) begin
      send(c / 2, (c % 2) == 0, c == 10, (c == 11) || (c == 14));
      if (c == 35) begin
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL gaps_early_done got=%0b exp=0", done); end
      end
    end
    idle_inputs();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL gaps_done got=%0b exp=1", done); end
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i]);
      n_cmp++; if (rd_I !== DW'(exp_i[i])) begin n_bad++; $display("FAIL gaps_rd addr=%0d got=%0d exp=%0d", addrs[i], $signed(rd_I), exp_i[i]); end
    end
  endtask

  task automatic test_control();
    trig_mode = 1'b1;
    // Abort in POST: trigger at n=20 (start_ptr 0), abort after n=21.
    pulse_arm();
    for (int n = 0; n <= 21; n++) send(n, 1'b1, n == 20, 1'b0);
    n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL ctl_post state=%0d exp=3", state_o); end
    idle_inputs();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++; if (state_o !== 3'd0 || done !== 1'b0) begin n_bad++; $display("FAIL ctl_abort state=%0d done=%0b exp=0/0", state_o, done); end
    for (int n = 22; n <= 40; n++) send(n, 1'b1, 1'b1, 1'b0);
    idle_inputs();
    do_read(5);
    n_cmp++; if (rd_I !== DW'(21)) begin n_bad++; $display("FAIL ctl_abort_addr5 got=%0d exp=21", $signed(rd_I)); end
    do_read(6);
    n_cmp++; if (rd_I !== DW'(6)) begin n_bad++; $display("FAIL ctl_abort_nowrite addr6 got=%0d exp=6", $signed(rd_I)); end
    do_read(7);
    n_cmp++; if (rd_I !== DW'(7)) begin n_bad++; $display("FAIL ctl_abort_nowrite addr7 got=%0d exp=7", $signed(rd_I)); end

    // arm and abort together: abort wins.
    arm   = 1'b1;
    abort = 1'b1;
    step();
    arm   = 1'b0;
    abort = 1'b0;
    send(0, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL ctl_arm_abort state=%0d exp=0", state_o); end

    // arm during POST is ignored.
    pulse_arm();
    for (int n = 0; n <= 21; n++) begin
      arm = (n == 12);
      send(n, 1'b1, n == 10, 1'b0);
      if (n == 12) begin
        n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL ctl_arm_in_post state=%0d exp=3", state_o); end
      end
    end
    arm = 1'b0;
    idle_inputs();
    n_cmp++; if (done !== 1'b1 || state_o !== 3'd4) begin n_bad++; $display("FAIL ctl_post_arm_done done=%0b state=%0d exp=1/4", done, state_o); end
    do_read(0);
    n_cmp++; if (rd_I !== DW'(6)) begin n_bad++; $display("FAIL ctl_post_arm_addr0 got=%0d exp=6", $signed(rd_I)); end

    // Re-arm from DONE, then a second capture with trigger at n=5.
    pulse_arm();
    n_cmp++; if (done !== 1'b0 || state_o !== 3'd1) begin n_bad++; $display("FAIL ctl_rearm done=%0b state=%0d exp=0/1", done, state_o); end
    for (int n = 0; n <= 16; n++) send(n, 1'b1, n == 5, 1'b0);
    idle_inputs();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ctl_second_done got=%0b exp=1", done); end
    do_read(0);
    n_cmp++; if (rd_I !== DW'(1)) begin n_bad++; $display("FAIL ctl_second_addr0 got=%0d exp=1", $signed(rd_I)); end
    do_read(4);
    n_cmp++; if (rd_I !== DW'(5)) begin n_bad++; $display("FAIL ctl_second_addr4 got=%0d exp=5", $signed(rd_I)); end
    do_read(15);
    n_cmp++; if (rd_I !== DW'(16) || rd_Q !== DW'(-16)) begin n_bad++; $display("FAIL ctl_second_addr15 got=%0d/%0d exp=16/-16", $signed(rd_I), $signed(rd_Q)); end
  endtask

  initial begin
    rst_n     = 1'b0;
    din_I     = '0;
    din_Q     = '0;
    din_valid = 1'b0;
    sym_tick  = 1'b0;
    ext_trig  = 1'b0;
    trig_mode = 1'b1;
    arm       = 1'b0;
    abort     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;

    test_reset();
    test_basic();
    test_reset_midrun();
    test_early_trigger();
    test_wrap();
    test_mode0_gaps();
    test_control();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iq_capture_buf.md
Name: iq_capture_buf

Overview:
- Trigger-based I/Q snapshot buffer that sits directly downstream of the TX subsystem output (tx_I/tx_Q/tx_valid/sym_tick).
- Continuously records filtered samples into a ring buffer.
- On a trigger, freezes a window of PRETRIG samples before the trigger and DEPTH-PRETRIG samples from the trigger onward.
- Exposes the window through a random-access read port ordered oldest-first, for debug readout and constellation/eye capture.

Parameters:
- DATA_W, 12, sample width (Q1.11, matches sample_t).
- DEPTH, 256, capture window length in samples; power of 2, at least 4.
- PRETRIG, 32, samples kept before the trigger sample; 0 <= PRETRIG < DEPTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- din_I  in  DATA_W  I sample (signed)
- din_Q  in  DATA_W  Q sample (signed)
- din_valid  in  1  sample strobe
- sym_tick  in  1  symbol-rate strobe (trigger source, mode 0)
- ext_trig  in  1  external trigger (trigger source, mode 1)
- trig_mode  in  1  0 = sym_tick, 1 = ext_trig
- arm  in  1  single-cycle start-capture pulse
- abort  in  1  single-cycle cancel pulse
- rd_en  in  1  read request
- rd_addr  in  $clog2(DEPTH)  logical index; 0 = oldest captured sample
- rd_I  out  DATA_W  read I data
- rd_Q  out  DATA_W  read Q data
- rd_valid  out  1  read data valid
- state_o  out  3  FSM state, for debug
- done  out  1  capture complete, buffer frozen

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE; done=0, rd_I=0, rd_Q=0, rd_valid=0; wr_ptr, start_ptr and counters = 0.
  - Memory contents are not reset.
- State encoding: IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4.
- Write rule: in PREFILL, ARMED and POST, each din_valid=1 cycle writes {din_I, din_Q} to mem[wr_ptr], then wr_ptr increments modulo DEPTH. No writes occur in IDLE or DONE.
- Command priority: abort (any state) -> IDLE and done=0; abort wins over arm in the same cycle.
- IDLE or DONE, arm=1: -> PREFILL; wr_ptr=0, pre_cnt=0, done=0.
  - If PRETRIG=0, go directly to ARMED.
  - arm in PREFILL, ARMED or POST is ignored.
- PREFILL: pre_cnt counts written samples. On the write that makes pre_cnt==PRETRIG, go to ARMED on the next cycle. Triggers are ignored in PREFILL.
- ARMED: writes continue around the ring.
  - Trigger = selected source AND din_valid in the same cycle. A trigger without din_valid is ignored; there is no latching.
  - On trigger, the current sample is the trigger sample and is written.
  - start_ptr <= (wr_ptr - PRETRIG) mod DEPTH; post_cnt=1.
  - Next state is POST, or DONE if DEPTH-PRETRIG==1.
- POST: post_cnt increments per write. The write that makes post_cnt==DEPTH-PRETRIG moves the FSM to DONE. Trigger inputs are ignored.
- DONE: done=1 and is held until arm or abort. The buffer is frozen.
- Read port:
  - Latency is 1 cycle. rd_valid is registered copy of rd_en.
  - On rd_en, rd_I and rd_Q load mem[(start_ptr + rd_addr) mod DEPTH]; otherwise rd_I and rd_Q hold their value.
  - Reads are allowed in every state, but data is defined only in DONE.
  - Logical index PRETRIG is always the trigger sample.
- Memory: simple dual-port, 1 write and 1 read per cycle, inferable as block RAM. Read-during-write ordering is irrelevant because no writes occur in DONE.
- Pointer arithmetic: unsigned, width $clog2(DEPTH), wraps naturally.
- Reset mid-capture returns to IDLE immediately; a new arm is required.

Test Plan:
Bench uses DEPTH=16, PRETRIG=4, din_valid=1 continuous, and a ramp din_I=n, din_Q=-n (n = sample number since arm, starting at 0).
1. Reset: assert rst_n=0 mid-run -> state_o=0, done=0, rd_I=rd_Q=0, rd_valid=0 asynchronously. Release reset with no arm -> no state change, done stays 0.
2. Mode 1, basic capture: arm, ext_trig at n=10 -> done=1 after n=21 is written, state_o=4. rd_addr 0..15 returns I=6..21 and Q=-6..-21, with rd_valid one cycle after each rd_en; rd_addr=4 returns I=10.
3. Early trigger: ext_trig at n=2 (PREFILL) is ignored; ext_trig at n=7 is accepted -> addr0 I=3, addr4 I=7, addr15 I=18.
4. Wrap: ext_trig at n=40 -> addr0 I=36, addr15 I=51; correct ordering is required across the ring wrap.
5. Mode 0 with gaps: din_valid toggles 1/0. sym_tick on a din_valid=0 cycle is ignored; the first sym_tick coinciding with a valid sample of value v -> addr4 I=v. Samples in the window are consecutive valid samples only.
6. Control:
   - abort in POST -> state_o=0, done=0, and later samples are not written.
   - arm and abort in the same cycle -> IDLE.
   - arm in DONE -> done=0 and state_o=1; a second capture then succeeds.
   - arm during POST is ignored.
